ws_writeback: RTL

Parametrised write-back stage for the decoder's 8x8 block pipeline. It reads a finished 64-entry block of signed 16-bit samples from the dual-port embedded RAM and clips each sample to 8 bits. It packs pixel pairs into 16-bit words and writes them to external SRAM in raster position. It walks Y, then U, then V blocks of a full frame autonomously, and supports configurable image size, plane base addresses, chroma horizontal decimation and source half-word selection.

---
 rtl/ws_writeback_if.sv | 42 ++++
 rtl/ws_writeback.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ws_writeback_if.sv
// ws_writeback_if
// Bundles the write-back stage's control handshake, its DP-RAM read port and
// its external SRAM write port.
//   master : the write-back stage (drives reads, SRAM writes and status)
//   slave  : the environment (sequencer, DP-RAM, SRAM)
// Signals:
//   WS_start        start one block (sampled only while idle)
//   WS_done         one-cycle pulse after a block's last SRAM write
//   frame_done      one-cycle pulse with WS_done for the last V block
//   channel         plane of the current/next block: 0 Y, 1 U, 2 V
//   src_half        0 reads s_read_data[31:16], 1 reads [15:0]
//   s_read_address  DP-RAM read address 0..63
//   s_read_data     DP-RAM read data, one-cycle latency
//   s_write_enable  DP-RAM write enable, never asserted
//   SRAM_address    SRAM word address
//   SRAM_we_n       SRAM write enable, active-low
//   SRAM_write_data {even pixel, odd pixel}
interface ws_writeback_if;
  logic        WS_start;
  logic        WS_done;
  logic        frame_done;
  logic [1:0]  channel;
  logic        src_half;
  logic [6:0]  s_read_address;
  logic [31:0] s_read_data;
  logic        s_write_enable;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_write_data;

  modport master (
    input  WS_start, src_half, s_read_data,
    output WS_done, frame_done, channel, s_read_address, s_write_enable,
           SRAM_address, SRAM_we_n, SRAM_write_data
  );

  modport slave (
    output WS_start, src_half, s_read_data,
    input  WS_done, frame_done, channel, s_read_address, s_write_enable,
           SRAM_address, SRAM_we_n, SRAM_write_data
  );
endinterface

// File: rtl/ws_writeback.sv
// ws_writeback
// Write-back stage of the 8x8 block pipeline. For each started block it reads
// 64 signed 16-bit samples from the DP-RAM, clips them to 8 bits, packs pixel
// pairs into 16-bit words and writes 32 words into external SRAM at the block's
// raster position. Block position walks all Y blocks, then U, then V of a frame.
// Ports:
//   CLOCK_50_I  clock, rising edge
//   Resetn      asynchronous active-low reset
//   bus         ws_writeback_if.master (handshake, DP-RAM read, SRAM write)
module ws_writeback #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int Y_BASE     = 0,
  parameter int U_BASE     = 38400,
  parameter int V_BASE     = 57600,
  parameter int CHROMA_DIV = 2
) (
  input  logic           CLOCK_50_I,
  input  logic           Resetn,
  ws_writeback_if.master bus
);
  // Words per SRAM row for luma and chroma planes.
  localparam logic [17:0] W_Y       = 18'(IMG_WIDTH / 2);
  localparam logic [17:0] W_C       = 18'(IMG_WIDTH / (2 * CHROMA_DIV));
  localparam logic [17:0] CB_LAST_Y = 18'(IMG_WIDTH / 8 - 1);
  localparam logic [17:0] CB_LAST_C = 18'(IMG_WIDTH / (8 * CHROMA_DIV) - 1);
  localparam logic [17:0] RB_LAST   = 18'(IMG_HEIGHT / 8 - 1);
  localparam logic [17:0] Y_BASE_W  = 18'(Y_BASE);
  localparam logic [17:0] U_BASE_W  = 18'(U_BASE);
  localparam logic [17:0] V_BASE_W  = 18'(V_BASE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL1, S_TAIL2} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  k_reg;          // read index during S_RUN, 0 while idle
  logic        dvalid_reg;     // s_read_data holds sample dk_reg this cycle
  logic [5:0]  dk_reg;
  logic        half_reg;
  logic [7:0]  even_byte_reg;
  logic [17:0] cb_reg, rb_reg;
  logic [1:0]  channel_reg;
  logic [17:0] addr_reg;
  logic [15:0] wdata_reg;
  logic        we_n_reg;
  logic        done_reg, frame_reg;

  logic        start_accept, run, block_end;
  logic [15:0] sel_sample;
  logic [7:0]  clip_byte;
  logic        cb_at_last, rb_at_last;
  logic [17:0] row_idx, plane_base, write_addr;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.WS_start) state_next = S_RUN;
      S_RUN:   if (k_reg == 6'd63) state_next = S_TAIL1;
      S_TAIL1: state_next = S_TAIL2;
      S_TAIL2: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    start_accept = 1'b0;
    run          = 1'b0;
    block_end    = 1'b0;
    case (state_reg)
      S_IDLE:  start_accept = bus.WS_start;
      S_RUN:   run = 1'b1;
      S_TAIL2: block_end = 1'b1;
      default: ;
    endcase
  end

  // ---------------- clip ----------------
  assign sel_sample = half_reg ? bus.s_read_data[15:0] : bus.s_read_data[31:16];

  always_comb begin
    clip_byte = sel_sample[7:0];
    if (sel_sample[15])          clip_byte = 8'h00;
    else if (|sel_sample[14:8])  clip_byte = 8'hFF;
  end

  // ---------------- address: base + W*row + 4*CB + c/2 ----------------
  assign row_idx = (rb_reg << 3) + 18'(dk_reg[5:3]);

  // Constant multiply by the row stride as a shift-add chain: only the set
  // bits of the constant contribute an adder stage.
  logic [17:0] prod_y [19];
  logic [17:0] prod_c [19];
  assign prod_y[0] = '0;
  assign prod_c[0] = '0;
  for (genvar gi = 0; gi < 18; gi++) begin : g_mul
    if (W_Y[gi]) begin : g_y_add
      assign prod_y[gi+1] = prod_y[gi] + (row_idx << gi);
    end else begin : g_y_pass
      assign prod_y[gi+1] = prod_y[gi];
    end
    if (W_C[gi]) begin : g_c_add
      assign prod_c[gi+1] = prod_c[gi] + (row_idx << gi);
    end else begin : g_c_pass
      assign prod_c[gi+1] = prod_c[gi];
    end
  end

  always_comb begin
    case (channel_reg)
      2'd0:    plane_base = Y_BASE_W;
      2'd1:    plane_base = U_BASE_W;
      default: plane_base = V_BASE_W;
    endcase
  end

  assign write_addr = plane_base + ((channel_reg == 2'd0) ? prod_y[18] : prod_c[18])
                    + (cb_reg << 2) + 18'(dk_reg[2:1]);

  assign cb_at_last = (cb_reg == ((channel_reg == 2'd0) ? CB_LAST_Y : CB_LAST_C));
  assign rb_at_last = (rb_reg == RB_LAST);

  // ---------------- datapath ----------------
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      k_reg         <= '0;
      dvalid_reg    <= 1'b0;
      dk_reg        <= '0;
      half_reg      <= 1'b0;
      even_byte_reg <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_n_reg      <= 1'b1;
      done_reg      <= 1'b0;
      frame_reg     <= 1'b0;
      cb_reg        <= '0;
      rb_reg        <= '0;
      channel_reg   <= 2'd0;
    end else begin
      if (start_accept) half_reg <= bus.src_half;
      k_reg      <= run ? k_reg + 6'd1 : 6'd0;
      // Read data arrives one cycle after the address, so track which k it is.
      dvalid_reg <= run;
      dk_reg     <= k_reg;

      we_n_reg <= 1'b1;
      if (dvalid_reg) begin
        if (!dk_reg[0]) begin
          even_byte_reg <= clip_byte;
        end else begin
          we_n_reg  <= 1'b0;
          wdata_reg <= {even_byte_reg, clip_byte};
          addr_reg  <= write_addr;
        end
      end

      done_reg  <= block_end;
      frame_reg <= block_end && cb_at_last && rb_at_last && (channel_reg == 2'd2);

      if (block_end) begin
        if (cb_at_last) begin
          cb_reg <= '0;
          if (rb_at_last) begin
            rb_reg      <= '0;
            channel_reg <= (channel_reg == 2'd2) ? 2'd0 : channel_reg + 2'd1;
          end else begin
            rb_reg <= rb_reg + 18'd1;
          end
        end else begin
          cb_reg <= cb_reg + 18'd1;
        end
      end
    end
  end

  assign bus.s_read_address  = {1'b0, k_reg};
  assign bus.s_write_enable  = 1'b0;
  assign bus.SRAM_address    = addr_reg;
  assign bus.SRAM_we_n       = we_n_reg;
  assign bus.SRAM_write_data = wdata_reg;
  assign bus.WS_done         = done_reg;
  assign bus.frame_done      = frame_reg;
  assign bus.channel         = channel_reg;
endmodule
